// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Contents: nibble width, FSM state enum, index-width helper and, when
// ADDR_NIBBLE_RECOMPUTE_EN is defined, the compute/check phase enum.
package addr_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

`ifdef ADDR_NIBBLE_RECOMPUTE_EN
  typedef enum logic {
    PhCompute,
    PhCheck
  } phase_e;
`endif

  // Width of the nibble index; at least one bit so NIBBLES=1 still has a register.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/addr_nibble_seq_if.sv
// Operand/result handshake bundle for addr_nibble_seq.
// master: producer/consumer side (drives in_valid, a, b, cin, out_ready).
// slave:  sequencer side (drives in_ready, out_valid, sum, cout, err).
interface addr_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = addr_seq_pkg::NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

endinterface

// File: rtl/addr4_core.sv
// Combinational 4-bit unsigned adder with carry-in.
// Ports: a, b (4-bit operands), ci (carry-in) -> s (4-bit sum), co (carry-out).
// Port names are kept plain so alternative adder netlists drop in unchanged.
module addr4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/addr_nibble_seq.sv
// Nibble-serial wide adder: one shared addr4_core adds W=4*NIBBLES-bit operands
// LSB nibble first, carrying between nibbles in a register.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying
// in_valid/in_ready/a/b/cin and out_valid/out_ready/sum/cout/err.
// Optional macro ADDR_NIBBLE_RECOMPUTE_EN: each nibble is computed twice
// (second time with operands swapped) and any disagreement sets sticky err.
module addr_nibble_seq
  import addr_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  addr_nibble_seq_if.slave  bus
);

  localparam int unsigned IdxW = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

  state_e          state_q, state_d;
  word_t           a_q, a_d;
  word_t           b_q, b_d;
  word_t           sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [NIBBLE_W-1:0] core_a, core_b, core_s;
  logic                core_co;

`ifdef ADDR_NIBBLE_RECOMPUTE_EN
  phase_e              phase_q, phase_d;
  logic [NIBBLE_W:0]   shadow_q, shadow_d;
  logic                err_q, err_d;

  // Check phase feeds the core swapped operands so a fault that depends on
  // operand position shows up as a disagreement with the shadow copy.
  always_comb begin
    if (phase_q == PhCheck) begin
      core_a = b_q[idx_q];
      core_b = a_q[idx_q];
    end else begin
      core_a = a_q[idx_q];
      core_b = b_q[idx_q];
    end
  end
`else
  assign core_a = a_q[idx_q];
  assign core_b = b_q[idx_q];
`endif

  addr4_core u_core (
    .a  (core_a),
    .b  (core_b),
    .ci (carry_q),
    .s  (core_s),
    .co (core_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
    phase_d  = phase_q;
    shadow_d = shadow_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          carry_d = bus.cin;
          state_d = StRun;
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
          phase_d = PhCompute;
          err_d   = 1'b0;
`endif
        end
      end
      StRun: begin
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
        if (phase_q == PhCompute) begin
          // Commit the first-pass sum now; carry waits so the check uses the same carry-in.
          sum_d[idx_q] = core_s;
          shadow_d     = {core_co, core_s};
          phase_d      = PhCheck;
        end else begin
          if ({core_co, core_s} != shadow_q) err_d = 1'b1;
          carry_d = shadow_q[NIBBLE_W];
          phase_d = PhCompute;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_d  = shadow_q[NIBBLE_W];
            state_d = StDone;
          end
        end
`else
        sum_d[idx_q] = core_s;
        carry_d      = core_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = core_co;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
      phase_q  <= PhCompute;
      shadow_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
`endif
    end
  end

  // Gated by rst_n so the producer never sees ready while the block is held in reset.
  assign bus.in_ready  = rst_n && (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef ADDR_NIBBLE_RECOMPUTE_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
